// File: rtl/and_response_checker.sv
// Golden registered-AND checker for the AND test chip: ages {a,b} by LATENCY cycles,
// compares the expected a&b against the chip output y and keeps run statistics.
module and_response_checker #(
  parameter int LATENCY     = 2,
  parameter int SETTLE      = 4,
  parameter int CNT_W       = 16,
  parameter int FAIL_THRESH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [1:0]       first_err_ab,
  output logic             first_err_valid
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAIL_THRESH);

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("and_response_checker: LATENCY must be in 1..8");
  end
  if (SETTLE < LATENCY) begin : g_bad_settle
    $error("and_response_checker: SETTLE must be >= LATENCY");
  end
  if (FAIL_THRESH < 1 || longint'(FAIL_THRESH) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_thresh
    $error("and_response_checker: FAIL_THRESH out of range for CNT_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [SW-1:0]     settle_ctr;
  logic [1:0]        hist_p [LATENCY];
  logic [1:0]        aged_ab;
  logic              exp_y;
  logic              mis;
  logic              shift_en;
  logic [CNT_W-1:0]  sample_nxt;
  logic [CNT_W-1:0]  mismatch_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != CNT_MAX) ? v + 1'b1 : v;
  endfunction

  // Compare stage: oldest history entry against the chip output
  assign aged_ab      = hist_p[LATENCY-1];
  assign exp_y        = aged_ab[1] & aged_ab[0];
  assign mis          = (y != exp_y);
  assign shift_en     = (state == S_SETTLE) || (state == S_RUN);
  assign sample_nxt   = sat_inc(sample_cnt, 1'b1);
  assign mismatch_nxt = sat_inc(mismatch_cnt, mis);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      settle_ctr      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      fail            <= 1'b0;
      sample_cnt      <= '0;
      mismatch_cnt    <= '0;
      first_err_idx   <= '0;
      first_err_ab    <= 2'b00;
      first_err_valid <= 1'b0;
      for (int i = 0; i < LATENCY; i++) hist_p[i] <= 2'b00;
    end else begin
      if (shift_en) begin
        hist_p[0] <= {a, b};
        for (int i = 1; i < LATENCY; i++) hist_p[i] <= hist_p[i-1];
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state           <= S_SETTLE;
            settle_ctr      <= SW'(SETTLE - 1);
            busy            <= 1'b1;
            done            <= 1'b0;
            fail            <= 1'b0;
            sample_cnt      <= '0;
            mismatch_cnt    <= '0;
            first_err_idx   <= '0;
            first_err_ab    <= 2'b00;
            first_err_valid <= 1'b0;
            for (int i = 0; i < LATENCY; i++) hist_p[i] <= 2'b00;
          end
        end
        S_SETTLE: begin
          // stop has priority over the move into RUN
          if (stop) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (settle_ctr == '0) begin
            state <= S_RUN;
          end else begin
            settle_ctr <= settle_ctr - 1'b1;
          end
        end
        S_RUN: begin
          sample_cnt   <= sample_nxt;
          mismatch_cnt <= mismatch_nxt;
          if (mis && !first_err_valid) begin
            first_err_idx   <= sample_cnt;
            first_err_ab    <= aged_ab;
            first_err_valid <= 1'b1;
          end
          if (mismatch_nxt >= THRESH) fail <= 1'b1;
          // end the run on stop, or before the sample counter could wrap
          if (stop || sample_nxt == CNT_MAX) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
